// File: rtl/freq_gen_pkg.sv
// freq_gen_pkg: shared state encoding and defaults for the clock-enable generator
package freq_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PEND} state_e;
  function automatic int half_from_freq(input int f_clk, input int f_out);
    return f_clk / (2 * f_out);
  endfunction
  localparam int CNT_W_DEF = 16;
  localparam int DEFAULT_HALF_DEF = half_from_freq(50_000_000, 2_500_000);
endpackage

// File: rtl/half_period_counter.sv
// half_period_counter: wrapping 0..half-1 counter with terminal flag
module half_period_counter
  import freq_gen_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] half,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             terminal
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign terminal = cnt_q == half - CNT_W'(1);
  assign cnt = cnt_q;
  always_comb cnt_d = clear ? '0 : !enable ? cnt_q : terminal ? '0 : cnt_q + CNT_W'(1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/freq_gen_ctrl.sv
// freq_gen_ctrl: square-wave generator with boundary-synchronised reconfiguration
module freq_gen_ctrl
  import freq_gen_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF,
  parameter bit AUTO_START   = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic             cfg_en,
  output logic             clk_out,
  output logic             rise,
  output logic             fall,
  output logic             running,
  output logic             cfg_err
);
  state_e           state_q;
  logic [CNT_W-1:0] half_q, sh_half_q, cnt;
  logic             sh_en_q, start_q, clk_out_q, rise_q, fall_q, cfg_err_q;
  logic             terminal, xfer, legal, count_en, tick;
  assign cfg_ready = state_q != PEND;
  assign running   = state_q != IDLE;
  assign clk_out   = clk_out_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign cfg_err   = cfg_err_q;
  assign xfer      = cfg_valid & cfg_ready;
  assign legal     = cfg_half != '0;
  // start_q holds the counter one extra cycle after an idle start
  assign count_en  = (state_q != IDLE) & ~start_q;
  assign tick      = count_en & terminal;
  half_period_counter #(.CNT_W(CNT_W)) u_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .half    (half_q),
    .clear   (~count_en),
    .enable  (count_en),
    .cnt     (cnt),
    .terminal(terminal)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q   <= AUTO_START ? RUN : IDLE;
      half_q    <= CNT_W'(DEFAULT_HALF);
      sh_half_q <= '0;
      sh_en_q   <= 1'b0;
      start_q   <= 1'b0;
      clk_out_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      rise_q    <= tick & ~clk_out_q;
      fall_q    <= tick & clk_out_q;
      cfg_err_q <= xfer & ~legal;
      start_q   <= 1'b0;
      if (tick) clk_out_q <= ~clk_out_q;
      case (state_q)
        IDLE: if (xfer && legal && cfg_en) begin
          half_q  <= cfg_half;
          start_q <= 1'b1;
          state_q <= RUN;
        end
        RUN: if (xfer && legal) begin
          sh_half_q <= cfg_half;
          sh_en_q   <= cfg_en;
          state_q   <= PEND;
        end
        PEND: if (tick && clk_out_q) begin
          if (sh_en_q) half_q <= sh_half_q;
          state_q <= sh_en_q ? RUN : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  a_cnt_in_range: assert property (@(posedge clock) disable iff (!reset_n) cnt < half_q);
endmodule

// File: tb/tb_freq_gen_ctrl.sv
// tb_freq_gen_ctrl: scoreboard bench comparing rise/fall/cfg_err events against hand-timed expectations
module tb_freq_gen_ctrl;
  typedef struct packed {
    int         cyc;
    logic [7:0] kind;
  } ev_t;
  logic        clock = 1'b0;
  logic        reset_n, cfg_valid, cfg_en;
  logic [15:0] cfg_half;
  logic        cfg_ready, clk_out, rise, fall, running, cfg_err;
  int          checks = 0, errors = 0, cyc;
  ev_t         sb[$];

  freq_gen_ctrl #(.CNT_W(16), .DEFAULT_HALF(10), .AUTO_START(1'b1)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_half (cfg_half),
    .cfg_en   (cfg_en),
    .clk_out  (clk_out),
    .rise     (rise),
    .fall     (fall),
    .running  (running),
    .cfg_err  (cfg_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%0b req=%0b", name, act, req);
    end
  endtask

  task automatic push(input int c, input logic [7:0] k);
    sb.push_back(ev_t'{cyc: c, kind: k});
  endtask

  task automatic mon(input logic [7:0] k);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_unexpected act=%s@%0d req=none", k, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind !== k || e.cyc != cyc) begin
        errors++;
        $display("FAIL sb_event act=%s@%0d req=%s@%0d", k, cyc, e.kind, e.cyc);
      end
    end
  endtask

  task automatic wait_cyc(input int n);
    int g = 0;
    while (cyc != n) begin
      @(negedge clock);
      g++;
      if (g > 300) begin
        checks++;
        errors++;
        $display("FAIL wait_cyc act=%0d req=%0d", cyc, n);
        break;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] h, input logic e);
    cfg_valid = v;
    cfg_half  = h;
    cfg_en    = e;
  endtask

  always @(negedge clock)
    if (reset_n) begin
      if (cfg_err) mon("E");
      if (rise) mon("R");
      if (fall) mon("F");
    end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout req=finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b1;
    drive(1'b0, 16'd0, 1'b0);
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_clk_out", clk_out, 1'b0);
    chk("rst_ready", cfg_ready, 1'b1);
    chk("rst_running", running, 1'b1);
    chk("rst_rise", rise, 1'b0);
    chk("rst_fall", fall, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
    push(10, "R"); push(20, "F"); push(24, "R"); push(28, "F"); push(32, "R"); push(36, "F");
    reset_n = 1'b1;
    // retune to half=4 mid high phase
    wait_cyc(13); drive(1'b1, 16'd4, 1'b1);
    wait_cyc(14); drive(1'b0, 16'd0, 1'b0);
    chk("pend_ready_lo", cfg_ready, 1'b0);
    chk("pend_running", running, 1'b1);
    wait_cyc(19);
    chk("pend_ready_hold", cfg_ready, 1'b0);
    chk("pend_high_phase", clk_out, 1'b1);
    wait_cyc(20);
    chk("apply_ready_hi", cfg_ready, 1'b1);
    chk("apply_fell", clk_out, 1'b0);
    // stop request
    wait_cyc(29); drive(1'b1, 16'd7, 1'b0);
    wait_cyc(30); drive(1'b0, 16'd0, 1'b0);
    chk("stop_ready_lo", cfg_ready, 1'b0);
    wait_cyc(40);
    chk("idle_running", running, 1'b0);
    chk("idle_ready", cfg_ready, 1'b1);
    chk("idle_clk_out", clk_out, 1'b0);
    push(52, "R"); push(53, "F"); push(54, "R"); push(55, "F"); push(56, "R"); push(57, "F");
    push(67, "R"); push(71, "E"); push(77, "F"); push(87, "R"); push(97, "F"); push(107, "R");
    push(117, "F"); push(120, "R"); push(123, "F"); push(126, "R");
    // start from idle with half=1
    wait_cyc(49); drive(1'b1, 16'd1, 1'b1);
    wait_cyc(50); drive(1'b0, 16'd0, 1'b0);
    chk("start_running", running, 1'b1);
    chk("start_clk_low", clk_out, 1'b0);
    wait_cyc(55); drive(1'b1, 16'd10, 1'b1);
    wait_cyc(56); drive(1'b0, 16'd0, 1'b0);
    chk("h1_pend_ready", cfg_ready, 1'b0);
    wait_cyc(57);
    chk("h1_apply_ready", cfg_ready, 1'b1);
    // illegal zero half
    wait_cyc(70); drive(1'b1, 16'd0, 1'b1);
    wait_cyc(71); drive(1'b0, 16'd0, 1'b0);
    chk("err_ready", cfg_ready, 1'b1);
    chk("err_running", running, 1'b1);
    // request landing on the fall boundary waits for the next one
    wait_cyc(96); drive(1'b1, 16'd3, 1'b1);
    wait_cyc(97); drive(1'b0, 16'd0, 1'b0);
    chk("bnd_ready_lo", cfg_ready, 1'b0);
    wait_cyc(116);
    chk("bnd_ready_hold", cfg_ready, 1'b0);
    wait_cyc(117);
    chk("bnd_ready_hi", cfg_ready, 1'b1);
    // reset while pending in high phase
    wait_cyc(126); drive(1'b1, 16'd5, 1'b1);
    wait_cyc(127); drive(1'b0, 16'd0, 1'b0);
    chk("pr_ready_lo", cfg_ready, 1'b0);
    chk("pr_clk_hi", clk_out, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_clk_out", clk_out, 1'b0);
    chk("arst_ready", cfg_ready, 1'b1);
    chk("arst_running", running, 1'b1);
    chk("arst_rise", rise, 1'b0);
    repeat (2) @(negedge clock);
    push(10, "R"); push(20, "F"); push(30, "R"); push(40, "F");
    reset_n = 1'b1;
    wait_cyc(45);
    chk("post_rst_clk_low", clk_out, 1'b0);
    chk("sb_drained", sb.size() == 0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/freq_gen_ctrl.md
# freq_gen_ctrl

Synthesizable programmable clock-enable generator with a run-time reconfiguration controller. It produces a square wave on `clk_out` from the system clock: high for `half` cycles, then low for `half` cycles. It accepts new half-period and enable settings over a valid/ready handshake and applies them only at a period boundary, so `clk_out` never glitches. It replaces fixed-delay behavioural frequency generators wherever a derived-frequency strobe (e.g. 2.5 MHz from 50 MHz) feeds on-chip logic.

## Interface
- `CNT_W`, 16, width of the half-period counter and of `cfg_half`
- `DEFAULT_HALF`, 10, half-period in `clock` cycles loaded at reset (50 MHz / (2·10) = 2.5 MHz)
- `AUTO_START`, 1, 1 = generator runs out of reset; 0 = idle out of reset
- `clock`  in  1  system clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cfg_valid`  in  1  configuration request valid
- `cfg_ready`  out  1  controller can accept a configuration
- `cfg_half`  in  CNT_W  requested half-period in cycles; 0 is illegal
- `cfg_en`  in  1  requested run state (1 = run, 0 = stop)
- `clk_out`  out  1  generated square wave, registered
- `rise`  out  1  one-cycle pulse in the cycle `clk_out` goes 0→1
- `fall`  out  1  one-cycle pulse in the cycle `clk_out` goes 1→0 (period end)
- `running`  out  1  high in RUN and PEND
- `cfg_err`  out  1  one-cycle pulse: accepted request had `cfg_half`=0

## Operation
- States:
  - IDLE: `clk_out`=0, counter held at 0.
  - RUN: generating, no change pending.
  - PEND: generating, shadow configuration waiting for a boundary.
- Handshake:
  - `cfg_ready` = (state != PEND).
  - A transfer occurs when `cfg_valid & cfg_ready`.
  - `cfg_valid` may be held without a transfer; when `cfg_ready` is high, the request is taken that cycle.
- Illegal request: a transfer with `cfg_half`=0 pulses `cfg_err` next cycle and is otherwise discarded; state and settings are unchanged.
- Counter `cnt` counts 0..`half`−1.
  - When `cnt`=`half`−1: `clk_out` toggles and `cnt`←0.
  - Otherwise: `cnt`←`cnt`+1.
- IDLE + legal transfer with `cfg_en`=1: load `half`, `cnt`←0, `clk_out` stays 0, go to RUN. IDLE + `cfg_en`=0: no effect.
- RUN + legal transfer: store shadow {half, en}, go to PEND.
- PEND, at the high→low toggle (`cnt`=`half`−1 and `clk_out`=1):
  - `clk_out`←0, `cnt`←0.
  - If shadow en=1: `half`←shadow half, go to RUN. The new low phase already uses the new half.
  - If shadow en=0: go to IDLE.
- A low→high toggle never applies a pending change.
- Reset: `clk_out`=0, `cnt`=0, `half`=`DEFAULT_HALF`, shadow cleared.
  - State = RUN if `AUTO_START`=1, else IDLE.
  - `cfg_ready`=1, `rise`=`fall`=`cfg_err`=0.
  - `running`=`AUTO_START`.
- Reset asserted mid-period: every output returns to its reset value immediately (asynchronous). Any pending shadow is lost.

## Timing
- Period = 2·`half` clock cycles, 50 % duty, for every `half` ≥ 1.
  - `half`=1: `clk_out` toggles every cycle.
- From IDLE start (transfer at edge N): `clk_out` rises at edge N+1+`half`.
- `rise`/`fall` are registered together with `clk_out` and coincide with the `clk_out` edge.
- Worst-case latency from transfer in RUN to application: 2·`half` cycles.
- A transfer in the same cycle as the high→low boundary, while in RUN: the current boundary uses the old settings; the new settings apply at the next boundary.
- `cfg_half` ≥ 2^CNT_W is unrepresentable; no saturation logic is needed.

## Structure
- Package `freq_gen_pkg` contains:
  - the state enum {IDLE, RUN, PEND}
  - the `CNT_W` default
  - `DEFAULT_HALF` for 50 MHz→2.5 MHz
  - a helper constant function `half_from_freq(f_clk, f_out)` = f_clk/(2·f_out)
- Sub-module `half_period_counter`:
  - Inputs: `half`, `clear`, `enable`.
  - Outputs: `cnt`, `terminal` (`cnt`=`half`−1).
  - The controller FSM, shadow register and `clk_out` flop stay in `freq_gen_ctrl`.

## Test plan
- Reset with `AUTO_START`=1, `DEFAULT_HALF`=10 → `clk_out` first rises 10 cycles after reset release; period 20 cycles, duty 10/10, `rise`/`fall` one cycle each.
- In RUN, send `cfg_half`=4, `cfg_en`=1 while `clk_out` is high at `cnt`=3 → `cfg_ready` low until the next `fall`; old high phase completes (10 high total); then 4 low / 4 high.
- Send `cfg_en`=0 while RUN → `clk_out` finishes its current period, falls, then stays 0; `running`=0; `cfg_ready`=1.
- From IDLE, send `cfg_half`=1, `cfg_en`=1 → `clk_out` toggles every cycle starting 2 edges after transfer.
- Send `cfg_half`=0 in RUN → `cfg_err` pulses once, period unchanged at 20, state stays RUN.
- Assert `reset_n` low mid-high-phase while in PEND → `clk_out`=0 immediately; after release, a 20-cycle period resumes and the pending setting is not applied.
